fib_stream_gen: RTL and testbench

- Parametrised successor to the single-shot fibonacci FSM: generates a two-term recurrence stream from programmable seeds.
- Two modes: plain additive (Fibonacci/Lucas style, with overflow detection) and modular (term = (a+b) mod M).
- Terms leave one per accepted beat on a valid/ready stream with out_last.
- Feeds downstream checkers and accumulators; runs on the core clk domain.

---
 rtl/fib_pkg.sv | 18 +
 rtl/fib_step.sv | 31 +++
 rtl/fib_stream_gen.sv | 179 +++++++++++++++++
 tb/tb_fib_stream_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and default sizes for the recurrence stream generator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_MOD = 1'b1
  } fib_mode_e;

  localparam int FIB_WIDTH_DEF   = 64;
  localparam int FIB_ORDER_W_DEF = 16;

endpackage

// File: rtl/fib_step.sv
// Combinational next-term unit: sum of two terms, either plain (with carry-out)
// or reduced modulo m. The modular path assumes a < m and b < m, so a single
// conditional subtraction is exact and the result always fits in WIDTH bits.
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  fib_mode_e        mode,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] s;

  // Full-width add, then either report the carry or fold back below m.
  always_comb begin
    s     = {1'b0, a} + {1'b0, b};
    sum   = s[WIDTH-1:0];
    carry = s[WIDTH];
    if (mode == MODE_MOD) begin
      carry = 1'b0;
      // s - m is below m, so the low WIDTH bits of the difference are exact.
      if (s >= {1'b0, m}) sum = s[WIDTH-1:0] - m;
    end
  end

endmodule

// File: rtl/fib_stream_gen.sv
// Two-term recurrence stream generator (additive or modular) with a
// valid/ready output stream and out_last on the final term.
// Optional feature macro: FIB_STALL_CNT_EN adds the stall_cnt output.
//
// Handshake: a term transfers on a clock edge where out_valid & out_ready are
// both high; while out_valid is high and out_ready low, out_data and out_last
// hold stable, and out_valid never drops without a transfer except on clear.
module fib_stream_gen
  import fib_pkg::*;
#(
  parameter int WIDTH   = FIB_WIDTH_DEF,
  parameter int ORDER_W = FIB_ORDER_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   seed0,
  input  logic [WIDTH-1:0]   seed1,
  input  logic [WIDTH-1:0]   modulus,
  input  logic [ORDER_W-1:0] order,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               overflw,
`ifdef FIB_STALL_CNT_EN
  output logic [31:0]        stall_cnt,
`endif
  output logic               bad_cfg
);

  fib_state_e         state_q, state_d;
  fib_mode_e          mode_q, mode_d;
  logic [WIDTH-1:0]   cur_q, cur_d, nxt_q, nxt_d, mod_q, mod_d;
  logic [ORDER_W-1:0] idx_q, idx_d, order_q, order_d;
  logic               nxt_ovf_q, nxt_ovf_d;
  logic               overflw_q, overflw_d;
  logic               bad_cfg_q, bad_cfg_d;

  logic [WIDTH-1:0]   step_sum;
  logic               step_carry;
  logic [ORDER_W-1:0] last_idx;
  logic               cfg_bad, is_last, beat, accept_start;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a     (cur_q),
    .b     (nxt_q),
    .mode  (mode_q),
    .m     (mod_q),
    .sum   (step_sum),
    .carry (step_carry)
  );

  assign cfg_bad      = (fib_mode_e'(mode) == MODE_MOD) &&
                        ((modulus == '0) || (seed0 >= modulus) || (seed1 >= modulus));
  assign accept_start = (state_q == IDLE) && start && !cfg_bad && !clear;
  assign last_idx     = order_q - ORDER_W'(1);
  // nxt_ovf means the upcoming term wrapped, so the current one must be final.
  assign is_last      = (idx_q == last_idx) || nxt_ovf_q;
  assign beat         = (state_q == RUN) && out_ready;

  assign out_data  = cur_q;
  assign out_valid = (state_q == RUN);
  assign out_last  = (state_q == RUN) && is_last;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign overflw   = overflw_q;
  assign bad_cfg   = bad_cfg_q;

  // Next-state and datapath update: clear first, then start/beat handling.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    mod_d     = mod_q;
    idx_d     = idx_q;
    order_d   = order_q;
    nxt_ovf_d = nxt_ovf_q;
    overflw_d = overflw_q;
    bad_cfg_d = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      overflw_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              bad_cfg_d = 1'b1;
            end else begin
              mode_d    = fib_mode_e'(mode);
              mod_d     = modulus;
              order_d   = order;
              cur_d     = seed0;
              nxt_d     = seed1;
              idx_d     = '0;
              nxt_ovf_d = 1'b0;
              overflw_d = 1'b0;
              state_d   = (order == '0) ? DONE : RUN;
            end
          end
        end
        RUN: begin
          if (beat) begin
            if (is_last) begin
              state_d   = DONE;
              overflw_d = nxt_ovf_q && (idx_q != last_idx);
            end else begin
              cur_d     = nxt_q;
              nxt_d     = step_sum;
              nxt_ovf_d = nxt_ovf_q | step_carry;
              idx_d     = idx_q + ORDER_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_ADD;
      cur_q     <= '0;
      nxt_q     <= '0;
      mod_q     <= '0;
      idx_q     <= '0;
      order_q   <= '0;
      nxt_ovf_q <= 1'b0;
      overflw_q <= 1'b0;
      bad_cfg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      mod_q     <= mod_d;
      idx_q     <= idx_d;
      order_q   <= order_d;
      nxt_ovf_q <= nxt_ovf_d;
      overflw_q <= overflw_d;
      bad_cfg_q <= bad_cfg_d;
    end
  end

`ifdef FIB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of stalled cycles, restarted by clear or a new sequence.
  always_comb begin
    stall_d = stall_q;
    if (clear || accept_start) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  logic unused_accept;
  assign unused_accept = accept_start;
`endif

endmodule

// File: tb/tb_fib_stream_gen.sv
// Self-checking bench for fib_stream_gen at WIDTH=8: table-driven sequences,
// randomized sequences against a term-list model, and hand-written corner cases.
module tb_fib_stream_gen;

  localparam int W  = 8;
  localparam int OW = 8;
  localparam longint MAXV = 255;

  logic          clk = 1'b0;
  logic          reset, clear, start, mode, out_ready;
  logic [W-1:0]  seed0, seed1, modulus;
  logic [OW-1:0] order;
  logic [W-1:0]  out_data;
  logic          out_valid, out_last, busy, done, overflw, bad_cfg;
`ifdef FIB_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  fib_stream_gen #(.WIDTH(W), .ORDER_W(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .start     (start),
    .mode      (mode),
    .seed0     (seed0),
    .seed1     (seed1),
    .modulus   (modulus),
    .order     (order),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overflw   (overflw),
`ifdef FIB_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bad_cfg   (bad_cfg)
  );

  // Clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  bit           exp_ovf;
  int           n_beats, stalls;
  logic [W-1:0] last_val;

  typedef struct {
    bit  md;
    int  s0, s1, m, ord, pat;
    int  exp_count;
    int  exp_last;
    bit  exp_ovf;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list the recurrence terms with unbounded arithmetic; in ADD mode
  // the sequence is cut before the first term that does not fit in W bits.
  task automatic model(input bit md, input int s0, input int s1, input int m, input int ord);
    longint terms[$];
    longint t;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int k = 0; k < ord; k++) begin
      if (k == 0)      t = s0;
      else if (k == 1) t = s1;
      else if (md)     t = (terms[k-2] + terms[k-1]) % m;
      else             t = terms[k-2] + terms[k-1];
      if (!md && t > MAXV) begin
        exp_ovf = 1'b1;
        break;
      end
      terms.push_back(t);
      exp_q.push_back(t[W-1:0]);
    end
  endtask

  function automatic bit ready_of(input int pat, input int c);
    if (pat == 0) return 1'b1;
    if (pat == 1) return (c % 2) == 1;
    return 1'(($urandom_range(0, 1)));
  endfunction

  // Drive one full sequence and score every presented term.
  task automatic run_seq(input bit md, input int s0, input int s1, input int m,
                         input int ord, input int pat);
    bit got_done;
    model(md, s0, s1, m, ord);
    n_beats  = 0;
    stalls   = 0;
    last_val = '0;
    got_done = 1'b0;
    mode = md; seed0 = W'(s0); seed1 = W'(s1); modulus = W'(m); order = OW'(ord);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 600 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
        chk("valid_in_done", out_valid, 0);
      end else if (out_valid) begin
        bit rdy;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
          rdy = 1'b1;
        end else begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_last", out_last, exp_q.size() == 1);
          chk("busy_run", busy, 1);
          rdy = ready_of(pat, c);
        end
        out_ready = rdy;
        if (rdy) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          n_beats++;
          last_val = out_data;
        end else begin
          stalls++;
        end
        tick();
      end else begin
        chk("idle_before_done", 1, 0);
        tick();
      end
    end
    chk("done_seen", got_done, 1);
    chk("terms_left", exp_q.size(), 0);
    chk("overflw", overflw, exp_ovf);
`ifdef FIB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
    out_ready = 1'b1;
    tick();
    chk("done_pulse_end", done, 0);
    chk("busy_after", busy, 0);
  endtask

  vec_t vecs[9];

  initial begin
    reset = 1'b1; clear = 1'b0; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
    seed0 = '0; seed1 = '0; modulus = '0; order = '0;

    // Reset state.
    tick(); tick();
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", {busy, done, overflw, bad_cfg, out_last}, 0);
    reset = 1'b0;
    tick();

    vecs[0] = '{0, 0, 1, 0, 10, 0, 10, 34, 0};
    vecs[1] = '{0, 0, 1, 0, 20, 0, 14, 233, 1};
    vecs[2] = '{1, 0, 1, 10, 8, 0, 8, 3, 0};
    vecs[3] = '{0, 0, 1, 0, 10, 1, 10, 34, 0};
    vecs[4] = '{0, 2, 1, 0, 5, 2, 5, 7, 0};
    vecs[5] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{0, 200, 100, 0, 5, 1, 2, 100, 1};
    vecs[7] = '{0, 5, 9, 0, 1, 0, 1, 5, 0};
    vecs[8] = '{1, 254, 254, 255, 6, 2, 6, 247, 0};

    for (int i = 0; i < 9; i++) begin
      run_seq(vecs[i].md, vecs[i].s0, vecs[i].s1, vecs[i].m, vecs[i].ord, vecs[i].pat);
      chk($sformatf("vec%0d_count", i), n_beats, vecs[i].exp_count);
      chk($sformatf("vec%0d_last", i), last_val, vecs[i].exp_last);
      chk($sformatf("vec%0d_ovf", i), overflw, vecs[i].exp_ovf);
    end

    // Randomized sequences.
    for (int r = 0; r < 30; r++) begin
      bit md;
      int m, s0, s1;
      md = 1'(($urandom_range(0, 1)));
      m  = $urandom_range(1, 255);
      s0 = md ? $urandom_range(0, m - 1) : $urandom_range(0, 255);
      s1 = md ? $urandom_range(0, m - 1) : $urandom_range(0, 255);
      if (!md && r % 3 == 0) begin s0 = $urandom_range(0, 3); s1 = $urandom_range(0, 3); end
      run_seq(md, s0, s1, m, $urandom_range(0, 25), $urandom_range(0, 2));
    end

    // Rejected start keeps a previous overflow flag.
    run_seq(0, 0, 1, 0, 20, 0);
    mode = 1'b1; modulus = 8'd5; seed0 = 8'd0; seed1 = 8'd7; order = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_cfg_pulse", bad_cfg, 1);
    chk("bad_cfg_busy", busy, 0);
    chk("bad_cfg_valid", out_valid, 0);
    chk("bad_cfg_ovf_kept", overflw, 1);
    tick();
    chk("bad_cfg_one_cycle", bad_cfg, 0);
    chk("bad_cfg_still_idle", out_valid, 0);

    // Modulus of zero is rejected too.
    mode = 1'b1; modulus = 8'd0; seed0 = 8'd0; seed1 = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_cfg_m0", bad_cfg, 1);
    tick();

    // Clear in IDLE drops the sticky overflow flag.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_ovf", overflw, 0);

    // Clear at term 4 aborts without a done pulse, beating a same-cycle accept.
    mode = 1'b0; seed0 = 8'd0; seed1 = 8'd1; order = 8'd10; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_clear_term4", out_data, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_valid", out_valid, 0);
    chk("clear_busy", busy, 0);
    chk("clear_no_done", done, 0);
    tick();
    chk("clear_no_done_later", done, 0);
    chk("clear_idle", out_valid, 0);

    // Start during RUN is ignored.
    start = 1'b1; order = 8'd3;
    tick();
    out_ready = 1'b0;
    seed0 = 8'd9;
    tick();
    chk("start_in_run_data", out_data, 0);
    chk("start_in_run_bad", bad_cfg, 0);
    start = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("post_run_idle", out_valid, 0);

    // Asynchronous reset mid-RUN.
    seed0 = 8'd5; seed1 = 8'd8; order = 8'd10; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_data", out_data, 0);
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_flags", {busy, done, overflw, bad_cfg, out_last}, 0);
    tick();
    reset = 1'b0;
    tick();

    // A fresh sequence after reset still works.
    run_seq(0, 1, 1, 0, 6, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
